// File: rtl/calc_operand_sequencer.sv
// Collects x, y and op from one switch bank (one item per enter press), drives them to the calculator, then
// captures its outputs SETTLE_CYCLES edges later; no backpressure: presses during the settle window are dropped.
module calc_operand_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic [1:0] op_in,
    input  logic       enter,
    input  logic       clear,
    output logic [3:0] x_out,
    output logic [3:0] y_out,
    output logic [1:0] op_sel_out,
    input  logic [7:0] calc_result,
    input  logic       calc_carry,
    input  logic       calc_overflow,
    output logic [7:0] res_q,
    output logic       carry_q,
    output logic       ovf_q,
    output logic       res_valid,
    output logic [2:0] state_q,
    output logic [7:0] op_count
);

    typedef enum logic [2:0] {
        GET_X  = 3'd0,
        GET_Y  = 3'd1,
        GET_OP = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     fsm_q, fsm_d;
    logic       sync1_q, sync2_q, prev_q;
    logic       enter_p;
    logic [3:0] x_q, x_d, y_q, y_d;
    logic [1:0] op_q, op_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] res_d;
    logic       carry_d, ovf_d;
    logic       vld_q, vld_d;
    logic [7:0] opcnt_q, opcnt_d;

    // Two-flop synchroniser plus a history flop gives one pulse per press.
    assign enter_p = sync2_q & ~prev_q;

    always_comb begin
        fsm_d   = fsm_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        vld_d   = vld_q;
        opcnt_d = opcnt_q;

        if (clear) begin
            fsm_d   = GET_X;
            x_d     = 4'd0;
            y_d     = 4'd0;
            op_d    = 2'd0;
            res_d   = 8'd0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            vld_d   = 1'b0;
        end else begin
            case (fsm_q)
                GET_X: begin
                    if (enter_p) begin
                        x_d   = data_in;
                        fsm_d = GET_Y;
                    end
                end
                GET_Y: begin
                    if (enter_p) begin
                        y_d   = data_in;
                        fsm_d = GET_OP;
                    end
                end
                GET_OP: begin
                    if (enter_p) begin
                        op_d  = op_in;
                        cnt_d = SETTLE_LOAD;
                        fsm_d = SETTLE;
                    end
                end
                SETTLE: begin
                    // Calculator inputs are frozen here; enter pulses are deliberately dropped.
                    if (cnt_q == 4'd0) begin
                        res_d   = calc_result;
                        carry_d = calc_carry;
                        ovf_d   = calc_overflow;
                        vld_d   = 1'b1;
                        opcnt_d = opcnt_q + 8'd1;
                        fsm_d   = DONE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    if (enter_p) begin
                        x_d   = data_in;
                        vld_d = 1'b0;
                        fsm_d = GET_Y;
                    end
                end
                default: fsm_d = GET_X;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= GET_X;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            x_q     <= 4'd0;
            y_q     <= 4'd0;
            op_q    <= 2'd0;
            cnt_q   <= 4'd0;
            res_q   <= 8'd0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
            opcnt_q <= 8'd0;
        end else begin
            fsm_q   <= fsm_d;
            sync1_q <= enter;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            x_q     <= x_d;
            y_q     <= y_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            vld_q   <= vld_d;
            opcnt_q <= opcnt_d;
        end
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign op_sel_out = op_q;
    assign res_valid  = vld_q;
    assign state_q    = fsm_q;
    assign op_count   = opcnt_q;

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Directed bench for calc_operand_sequencer with a small calculator stub and hand-computed expectations.
module tb_calc_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic [1:0] op_in = 2'd0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] x_out, y_out;
    logic [1:0] op_sel_out;
    logic [7:0] calc_result;
    logic       calc_carry, calc_overflow;
    logic [7:0] res_q;
    logic       carry_q, ovf_q, res_valid;
    logic [2:0] state_q;
    logic [7:0] op_count;

    logic       ovr_en = 1'b0;
    logic [7:0] ovr_res = 8'd0;
    logic       ovr_c = 1'b0, ovr_v = 1'b0;
    logic [4:0] s5, d5;
    logic [7:0] stub_res;
    logic       stub_c, stub_v;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_cnt = 8'd0;

    always #5 clk = ~clk;

    calc_operand_sequencer #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .op_in(op_in),
        .enter(enter), .clear(clear), .x_out(x_out), .y_out(y_out),
        .op_sel_out(op_sel_out), .calc_result(calc_result),
        .calc_carry(calc_carry), .calc_overflow(calc_overflow),
        .res_q(res_q), .carry_q(carry_q), .ovf_q(ovf_q),
        .res_valid(res_valid), .state_q(state_q), .op_count(op_count)
    );

    // Calculator stub: 00 add, 01 subtract (carry = borrow), 1x multiply.
    always_comb begin
        s5       = {1'b0, x_out} + {1'b0, y_out};
        d5       = {1'b0, x_out} - {1'b0, y_out};
        stub_res = 8'd0;
        stub_c   = 1'b0;
        stub_v   = 1'b0;
        if (op_sel_out[1]) begin
            stub_res = {4'd0, x_out} * {4'd0, y_out};
        end else if (op_sel_out[0]) begin
            stub_res = {4'd0, d5[3:0]};
            stub_c   = d5[4];
            stub_v   = (x_out[3] != y_out[3]) && (d5[3] != x_out[3]);
        end else begin
            stub_res = {4'd0, s5[3:0]};
            stub_c   = s5[4];
            stub_v   = (x_out[3] == y_out[3]) && (s5[3] != x_out[3]);
        end
        calc_result   = ovr_en ? ovr_res : stub_res;
        calc_carry    = ovr_en ? ovr_c : stub_c;
        calc_overflow = ovr_en ? ovr_v : stub_v;
    end

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [1:0] op;
        logic [7:0] res;
        logic       c;
        logic       v;
    } vec_t;

    vec_t vt[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One press: enter high for three edges (capture on the third), then low for three.
    task automatic press(input logic [3:0] d, input logic [1:0] o);
        @(posedge clk); #1;
        data_in = d;
        op_in   = o;
        enter   = 1'b1;
        repeat (3) @(posedge clk);
        #1 enter = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Leaves enter high and returns 1ns after the GET_OP->SETTLE edge.
    task automatic op_start(input logic [1:0] o);
        @(posedge clk); #1;
        op_in = o;
        enter = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    initial begin
        vt[0] = '{x: 4'h7, y: 4'h6, op: 2'b10, res: 8'h2A, c: 1'b0, v: 1'b0};
        vt[1] = '{x: 4'h9, y: 4'h8, op: 2'b00, res: 8'h01, c: 1'b1, v: 1'b1};
        vt[2] = '{x: 4'h3, y: 4'h4, op: 2'b00, res: 8'h07, c: 1'b0, v: 1'b0};
        vt[3] = '{x: 4'h5, y: 4'h3, op: 2'b01, res: 8'h02, c: 1'b0, v: 1'b0};
        vt[4] = '{x: 4'h2, y: 4'h5, op: 2'b01, res: 8'h0D, c: 1'b1, v: 1'b0};
        vt[5] = '{x: 4'hF, y: 4'hF, op: 2'b11, res: 8'hE1, c: 1'b0, v: 1'b0};
        vt[6] = '{x: 4'h7, y: 4'h1, op: 2'b00, res: 8'h08, c: 1'b0, v: 1'b1};
        vt[7] = '{x: 4'h8, y: 4'h1, op: 2'b01, res: 8'h07, c: 1'b0, v: 1'b1};

        #12;
        check("rst_state", 32'(state_q), 32'd0);
        check("rst_x", 32'(x_out), 32'd0);
        check("rst_res", 32'(res_q), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_cnt", 32'(op_count), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            press(vt[i].x, 2'b00);
            press(vt[i].y, 2'b00);
            press(4'h0, vt[i].op);
            exp_cnt = exp_cnt + 8'd1;
            check("vec_state", 32'(state_q), 32'd4);
            check("vec_res", 32'(res_q), 32'(vt[i].res));
            check("vec_carry", 32'(carry_q), 32'(vt[i].c));
            check("vec_ovf", 32'(ovf_q), 32'(vt[i].v));
            check("vec_valid", 32'(res_valid), 32'd1);
            check("vec_cnt", 32'(op_count), 32'(exp_cnt));
            check("vec_xyop", {22'd0, x_out, y_out, op_sel_out}, {22'd0, vt[i].x, vt[i].y, vt[i].op});
        end

        // Re-enter from DONE: old result stays visible.
        press(4'hF, 2'b00);
        check("done_x", 32'(x_out), 32'hF);
        check("done_valid", 32'(res_valid), 32'd0);
        check("done_state", 32'(state_q), 32'd1);
        check("done_res_kept", 32'(res_q), 32'h07);

        do_clear();
        #1;
        check("clr_state", 32'(state_q), 32'd0);
        check("clr_res", 32'(res_q), 32'd0);
        check("clr_cnt_kept", 32'(op_count), 32'(exp_cnt));

        // Long hold yields exactly one capture.
        @(posedge clk); #1;
        data_in = 4'h3;
        enter   = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("hold_state", 32'(state_q), 32'd1);
        check("hold_x", 32'(x_out), 32'h3);
        enter = 1'b0;
        repeat (3) @(posedge clk);
        press(4'h4, 2'b00);

        // Op press with a glitch so a second pulse lands on the capture edge.
        @(posedge clk); #1;
        op_in = 2'b00;
        enter = 1'b1;
        @(posedge clk); #1 enter = 1'b0;
        @(posedge clk); #1 enter = 1'b1;
        repeat (3) @(posedge clk);
        #1 enter = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 8'd1;
        check("settle_ign_state", 32'(state_q), 32'd4);
        check("settle_ign_res", 32'(res_q), 32'h07);
        check("settle_ign_cnt", 32'(op_count), 32'(exp_cnt));
        check("settle_ign_x", 32'(x_out), 32'h3);

        // Calculator outputs are valid only on the capture edge.
        press(4'h1, 2'b00);
        press(4'h2, 2'b00);
        ovr_en  = 1'b1;
        ovr_res = 8'hFF;
        ovr_c   = 1'b0;
        ovr_v   = 1'b0;
        op_start(2'b00);
        @(posedge clk); #1;
        ovr_res = 8'h0C;
        ovr_c   = 1'b1;
        ovr_v   = 1'b1;
        @(posedge clk); #1;
        ovr_res = 8'h55;
        ovr_c   = 1'b0;
        ovr_v   = 1'b0;
        enter   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_cnt = exp_cnt + 8'd1;
        check("ovr_res", 32'(res_q), 32'h0C);
        check("ovr_carry", 32'(carry_q), 32'd1);
        check("ovr_ovf", 32'(ovf_q), 32'd1);
        ovr_en = 1'b0;

        // Clear during SETTLE aborts.
        press(4'h2, 2'b00);
        press(4'h3, 2'b00);
        op_start(2'b10);
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        check("abort_state", 32'(state_q), 32'd0);
        check("abort_res", {23'd0, res_q, carry_q}, 32'd0);
        check("abort_valid", 32'(res_valid), 32'd0);
        check("abort_xyop", {22'd0, x_out, y_out, op_sel_out}, 32'd0);
        enter = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_cnt", 32'(op_count), 32'(exp_cnt));

        // clear and enter pulse on the same edge in GET_Y.
        press(4'h6, 2'b00);
        @(posedge clk); #1;
        data_in = 4'h5;
        enter   = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        check("clr_pri_state", 32'(state_q), 32'd0);
        check("clr_pri_y", {24'd0, x_out, y_out}, 32'd0);
        enter = 1'b0;
        repeat (3) @(posedge clk);

        // Wrap op_count through 255 -> 0.
        while (exp_cnt != 8'd0) begin
            press(4'h1, 2'b00);
            press(4'h1, 2'b00);
            press(4'h0, 2'b00);
            exp_cnt = exp_cnt + 8'd1;
        end
        check("wrap_zero", 32'(op_count), 32'd0);
        check("wrap_res", 32'(res_q), 32'h02);
        press(4'h1, 2'b00);
        press(4'h1, 2'b00);
        press(4'h0, 2'b00);
        check("wrap_one", 32'(op_count), 32'd1);

        // Asynchronous reset mid-SETTLE.
        press(4'h4, 2'b00);
        press(4'h5, 2'b00);
        op_start(2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state_q), 32'd0);
        check("arst_xyop", {22'd0, x_out, y_out, op_sel_out}, 32'd0);
        check("arst_res", {22'd0, res_q, carry_q, ovf_q}, 32'd0);
        check("arst_cnt_vld", {23'd0, op_count, res_valid}, 32'd0);
        enter = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_capture", {23'd0, op_count, res_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
